antitheft_fsm_multi: RTL and testbench

Parametrised successor of the vehicle anti-theft controller. It supports N door sensors, runtime-reprogrammable delay intervals and an internal countdown timer driven by the 1 Hz enable, so no external timer block is needed. It sits between the debounced door/ignition inputs and the siren driver and status LED, and exposes its state and timer value for the display path.

---
 rtl/antitheft_fsm_multi_pkg.sv | 34 +++
 rtl/antitheft_fsm_multi_sec.sv | 39 +++
 rtl/antitheft_fsm_multi.sv | 175 +++++++++++++++++
 tb/tb_antitheft_fsm_multi.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/antitheft_fsm_multi_pkg.sv
// Shared definitions for the multi-door anti-theft controller: state codes,
// interval-select codes, default parameter values and a timed-state helper.
package antitheft_fsm_multi_pkg;

    typedef enum logic [2:0] {
        ST_ARMED      = 3'd0,
        ST_TRIGGERED  = 3'd1,
        ST_SOUND      = 3'd2,
        ST_DISARMED   = 3'd3,
        ST_WAIT_OPEN  = 3'd4,
        ST_WAIT_CLOSE = 3'd5,
        ST_ARM_DELAY  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        PROG_ARM = 2'd0,
        PROG_DRV = 2'd1,
        PROG_PAS = 2'd2,
        PROG_ALM = 2'd3
    } prog_sel_e;

    localparam int DEF_N_DOORS = 4;
    localparam int DEF_CNT_W   = 4;
    localparam int DEF_T_ARM   = 6;
    localparam int DEF_T_DRV   = 8;
    localparam int DEF_T_PAS   = 15;
    localparam int DEF_T_ALM   = 10;

    // States in which the countdown runs.
    function automatic logic is_timed(input state_e s);
        return (s == ST_TRIGGERED) || (s == ST_SOUND) || (s == ST_ARM_DELAY);
    endfunction

endpackage

// File: rtl/antitheft_fsm_multi_sec.sv
// Seconds countdown: loadable down-counter advanced by the 1 Hz tick.
// A tick while count==1 signals expiry, so a loaded value T lasts T ticks.
module sec_countdown #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_load_val;

    // A zero interval would never expire, so it behaves as one second.
    assign w_load_val = (load_val == '0) ? CNT_W'(1) : load_val;
    assign expired    = tick && (r_count == CNT_W'(1));
    assign count      = r_count;

    // Counter register: clear, then load (beats tick), then decrement.
    always_ff @(posedge clock) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= w_load_val;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/antitheft_fsm_multi.sv
// Vehicle anti-theft controller for N doors with reprogrammable delays and an
// internal seconds countdown. Outputs are decoded from registered state only.
module antitheft_fsm_multi
    import antitheft_fsm_multi_pkg::*;
#(
    parameter int N_DOORS   = DEF_N_DOORS,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int T_ARM_DEF = DEF_T_ARM,
    parameter int T_DRV_DEF = DEF_T_DRV,
    parameter int T_PAS_DEF = DEF_T_PAS,
    parameter int T_ALM_DEF = DEF_T_ALM
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       one_hz_enable,
    input  logic                       ignition,
    input  logic [N_DOORS-1:0]         door,
    input  logic                       reprogram,
    input  logic [1:0]                 prog_sel,
    input  logic [CNT_W-1:0]           prog_val,
    output logic                       siren,
    output logic                       status,
    output logic [2:0]                 state,
    output logic [$clog2(N_DOORS)-1:0] trig_door,
    output logic [CNT_W-1:0]           timer
);

    localparam int TD_W = $clog2(N_DOORS);

    state_e           r_state;
    state_e           w_next;
    logic             r_blink;
    logic [TD_W-1:0]  r_trig_door;
    logic [TD_W-1:0]  w_low_idx;
    logic             w_latch_trig;
    logic [CNT_W-1:0] r_t_arm;
    logic [CNT_W-1:0] r_t_drv;
    logic [CNT_W-1:0] r_t_pas;
    logic [CNT_W-1:0] r_t_alm;
    logic             w_any_door;
    logic             w_tick;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_clear;
    logic             w_expired;
    logic [CNT_W-1:0] w_count;

    assign w_any_door = |door;
    assign w_tick     = one_hz_enable && is_timed(r_state);
    assign w_clear    = !is_timed(w_next);

    sec_countdown #(.CNT_W(CNT_W)) u_countdown (
        .clock    (clock),
        .reset    (reset),
        .clear    (w_clear),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (w_tick),
        .count    (w_count),
        .expired  (w_expired)
    );

    // Lowest-numbered open door; the driver door (bit 0) naturally wins.
    always_comb begin
        w_low_idx = '0;
        for (int i = N_DOORS - 1; i >= 0; i--) begin
            if (door[i]) w_low_idx = TD_W'(i);
        end
    end

    // Next-state, timer load and trigger-latch decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_next       = r_state;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_latch_trig = 1'b0;
        unique case (r_state)
            ST_ARMED: begin
                if (ignition) begin
                    w_next = ST_DISARMED;
                end else if (w_any_door) begin
                    w_next       = ST_TRIGGERED;
                    w_load       = 1'b1;
                    w_load_val   = door[0] ? r_t_drv : r_t_pas;
                    w_latch_trig = 1'b1;
                end
            end
            ST_TRIGGERED: begin
                if (ignition) begin
                    w_next = ST_DISARMED;
                end else if (w_expired) begin
                    w_next     = ST_SOUND;
                    w_load     = 1'b1;
                    w_load_val = r_t_alm;
                end
            end
            ST_SOUND: begin
                if (ignition)       w_next = ST_DISARMED;
                else if (w_expired) w_next = ST_ARMED;
            end
            ST_DISARMED: begin
                if (!ignition) w_next = ST_WAIT_OPEN;
            end
            ST_WAIT_OPEN: begin
                if (ignition)     w_next = ST_DISARMED;
                else if (door[0]) w_next = ST_WAIT_CLOSE;
            end
            ST_WAIT_CLOSE: begin
                if (ignition) begin
                    w_next = ST_DISARMED;
                end else if (!w_any_door) begin
                    w_next     = ST_ARM_DELAY;
                    w_load     = 1'b1;
                    w_load_val = r_t_arm;
                end
            end
            ST_ARM_DELAY: begin
                if (ignition)        w_next = ST_DISARMED;
                else if (w_any_door) w_next = ST_WAIT_CLOSE;
                else if (w_expired)  w_next = ST_ARMED;
            end
            default: w_next = ST_ARMED;
        endcase
    end

    // State register and trigger-door latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_ARMED;
            r_trig_door <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch_trig) r_trig_door <= w_low_idx;
        end
    end

    // Status blink flop: toggles per second while staying armed, else cleared.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_blink <= 1'b0;
        end else if ((r_state == ST_ARMED) && (w_next == ST_ARMED)) begin
            if (one_hz_enable) r_blink <= ~r_blink;
        end else begin
            r_blink <= 1'b0;
        end
    end

    // Interval registers; a write lands after any same-edge load has used the old value.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_t_arm <= CNT_W'(T_ARM_DEF);
            r_t_drv <= CNT_W'(T_DRV_DEF);
            r_t_pas <= CNT_W'(T_PAS_DEF);
            r_t_alm <= CNT_W'(T_ALM_DEF);
        end else if (reprogram) begin
            unique case (prog_sel_e'(prog_sel))
                PROG_ARM: r_t_arm <= prog_val;
                PROG_DRV: r_t_drv <= prog_val;
                PROG_PAS: r_t_pas <= prog_val;
                PROG_ALM: r_t_alm <= prog_val;
                default:  r_t_arm <= r_t_arm;
            endcase
        end
    end

    assign state     = r_state;
    assign trig_door = r_trig_door;
    assign timer     = w_count;
    assign siren     = (r_state == ST_SOUND);
    assign status    = (r_state == ST_ARMED) ? r_blink
                     : ((r_state == ST_TRIGGERED) || (r_state == ST_SOUND));

endmodule

// File: tb/tb_antitheft_fsm_multi.sv
// Self-checking bench: a directed vector table, hand-written corner sequences,
// then randomized traffic compared against a behavioural model.
module tb_antitheft_fsm_multi;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       one_hz_enable = 1'b0;
    logic       ignition = 1'b0;
    logic [3:0] door = '0;
    logic       reprogram = 1'b0;
    logic [1:0] prog_sel = '0;
    logic [3:0] prog_val = '0;
    logic       siren;
    logic       status;
    logic [2:0] state;
    logic [1:0] trig_door;
    logic [3:0] timer;

    int errors = 0;
    int checks = 0;

    antitheft_fsm_multi #(
        .N_DOORS(4), .CNT_W(4), .T_ARM_DEF(6), .T_DRV_DEF(8),
        .T_PAS_DEF(15), .T_ALM_DEF(10)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .one_hz_enable (one_hz_enable),
        .ignition      (ignition),
        .door          (door),
        .reprogram     (reprogram),
        .prog_sel      (prog_sel),
        .prog_val      (prog_val),
        .siren         (siren),
        .status        (status),
        .state         (state),
        .trig_door     (trig_door),
        .timer         (timer)
    );

    always #5 clock = ~clock;

    // Behavioural model: mode number, seconds remaining, latched door, blink bit.
    int m_mode  = 0;
    int m_left  = 0;
    int m_trig  = 0;
    bit m_blink = 0;
    int m_int [4] = '{6, 8, 15, 10};

    function automatic int at_least_one(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_step();
        int  nm;
        int  nl;
        bit  counting;
        bit  done;
        int  low;
        nm = m_mode;
        nl = m_left;
        counting = (m_mode == 1) || (m_mode == 2) || (m_mode == 6);
        done = counting && one_hz_enable && (m_left == 1);
        if (counting && one_hz_enable && m_left > 0) nl = m_left - 1;
        low = 0;
        for (int i = 3; i >= 0; i--) if (door[i]) low = i;
        if (reset) begin
            m_mode = 0; m_left = 0; m_trig = 0; m_blink = 0;
            m_int = '{6, 8, 15, 10};
            return;
        end
        case (m_mode)
            0: if (ignition) nm = 3;
               else if (door != 0) begin
                   nm = 1; m_trig = low;
                   nl = at_least_one(door[0] ? m_int[1] : m_int[2]);
               end
            1: if (ignition) nm = 3;
               else if (done) begin nm = 2; nl = at_least_one(m_int[3]); end
            2: if (ignition) nm = 3; else if (done) nm = 0;
            3: if (!ignition) nm = 4;
            4: if (ignition) nm = 3; else if (door[0]) nm = 5;
            5: if (ignition) nm = 3;
               else if (door == 0) begin nm = 6; nl = at_least_one(m_int[0]); end
            6: if (ignition) nm = 3; else if (door != 0) nm = 5; else if (done) nm = 0;
            default: nm = 0;
        endcase
        if (!(nm == 1 || nm == 2 || nm == 6)) nl = 0;
        m_blink = (m_mode == 0 && nm == 0) ? (m_blink ^ one_hz_enable) : 1'b0;
        if (reprogram) m_int[prog_sel] = int'(prog_val);
        m_mode = nm;
        m_left = nl;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model, take the edge, drop single-cycle strobes.
    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
        reset = 1'b0;
        one_hz_enable = 1'b0;
        reprogram = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            one_hz_enable = 1'b1;
            cyc();
        end
    endtask

    // From DISARMED: release ignition, open and close driver door, wait arm delay.
    task automatic go_armed(input string tag);
        ignition = 1'b0; cyc();
        door = 4'b0001; cyc();
        door = 4'b0000; cyc();
        check({tag, ".arm_delay"}, timer, 6);
        ticks(6);
        check({tag, ".armed"}, state, 0);
    endtask

    typedef struct {
        bit       rst;
        bit       tick;
        bit       ign;
        bit [3:0] dr;
        int       st;
        int       tm;
        int       sir;
        int       sts;
        int       trg;
    } vec_t;

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{1, 0, 0, 4'b0000, 0, 0,  0, 0, 0};
        vecs[1]  = '{0, 1, 0, 4'b0000, 0, 0,  0, 1, 0};
        vecs[2]  = '{0, 1, 0, 4'b0000, 0, 0,  0, 0, 0};
        vecs[3]  = '{0, 0, 0, 4'b1001, 1, 8,  0, 1, 0};
        vecs[4]  = '{0, 1, 0, 4'b0000, 1, 7,  0, 1, 0};
        vecs[5]  = '{0, 0, 1, 4'b0000, 3, 0,  0, 0, 0};
        vecs[6]  = '{0, 0, 0, 4'b0000, 4, 0,  0, 0, 0};
        vecs[7]  = '{0, 0, 0, 4'b0001, 5, 0,  0, 0, 0};
        vecs[8]  = '{0, 0, 0, 4'b0000, 6, 6,  0, 0, 0};
        vecs[9]  = '{0, 1, 0, 4'b0000, 6, 5,  0, 0, 0};
        vecs[10] = '{0, 0, 0, 4'b0100, 5, 0,  0, 0, 0};
        vecs[11] = '{0, 0, 0, 4'b0000, 6, 6,  0, 0, 0};
        vecs[12] = '{0, 0, 1, 4'b0000, 3, 0,  0, 0, 0};
        vecs[13] = '{1, 0, 0, 4'b0000, 0, 0,  0, 0, 0};
        vecs[14] = '{0, 0, 0, 4'b0100, 1, 15, 0, 1, 2};

        @(negedge clock);
        for (int i = 0; i < 15; i++) begin
            reset = vecs[i].rst;
            one_hz_enable = vecs[i].tick;
            ignition = vecs[i].ign;
            door = vecs[i].dr;
            cyc();
            check($sformatf("vec%0d.state", i), state, vecs[i].st);
            check($sformatf("vec%0d.timer", i), timer, vecs[i].tm);
            check($sformatf("vec%0d.siren", i), siren, vecs[i].sir);
            check($sformatf("vec%0d.status", i), status, vecs[i].sts);
            check($sformatf("vec%0d.trig", i), trig_door, vecs[i].trg);
        end

        // Passenger trigger runs 15 ticks, siren 10 ticks, then re-arms.
        reset = 1'b1; door = '0; ignition = 1'b0; cyc();
        door = 4'b0100; cyc();
        check("pas.trig_door", trig_door, 2);
        check("pas.timer", timer, 15);
        door = 4'b0000;
        ticks(14);
        check("pas.last_sec_state", state, 1);
        check("pas.last_sec_timer", timer, 1);
        ticks(1);
        check("pas.sound_state", state, 2);
        check("pas.sound_siren", siren, 1);
        check("pas.sound_timer", timer, 10);
        ticks(10);
        check("pas.rearm_state", state, 0);
        check("pas.rearm_siren", siren, 0);

        // Driver wins on simultaneous open; ignition aborts countdown.
        door = 4'b1001; cyc();
        check("sim.trig_door", trig_door, 0);
        check("sim.timer", timer, 8);
        door = 4'b0000;
        ticks(5);
        check("ign.timer_before", timer, 3);
        ignition = 1'b1; cyc();
        check("ign.state", state, 3);
        check("ign.siren", siren, 0);
        check("ign.timer", timer, 0);

        // Reprogram mid-countdown does not disturb the running count.
        go_armed("rp1");
        door = 4'b0001; cyc();
        door = 4'b0000;
        ticks(3);
        check("rp.timer5", timer, 5);
        reprogram = 1'b1; prog_sel = 2'd1; prog_val = 4'd3; cyc();
        check("rp.timer_kept", timer, 5);
        ticks(4);
        check("rp.timer1", timer, 1);
        ticks(1);
        check("rp.expired_state", state, 2);
        ignition = 1'b1; cyc();
        go_armed("rp2");
        door = 4'b0001; cyc();
        door = 4'b0000;
        check("rp.new_drv", timer, 3);
        ignition = 1'b1; cyc();
        reprogram = 1'b1; prog_sel = 2'd1; prog_val = 4'd0; cyc();
        go_armed("rp3");
        door = 4'b0001; cyc();
        door = 4'b0000;
        check("rp.zero_as_one", timer, 1);
        ticks(1);
        check("rp.zero_sound", state, 2);

        // Reset on the same edge as a tick while sounding.
        reset = 1'b1; one_hz_enable = 1'b1; cyc();
        check("rst.state", state, 0);
        check("rst.siren", siren, 0);
        check("rst.timer", timer, 0);
        door = 4'b0001; cyc();
        door = 4'b0000;
        check("rst.default_drv", timer, 8);

        // Write and load on the same edge: load takes the old interval.
        ignition = 1'b1; cyc();
        go_armed("same1");
        door = 4'b0001; reprogram = 1'b1; prog_sel = 2'd1; prog_val = 4'd2; cyc();
        door = 4'b0000;
        check("same.old_val", timer, 8);
        ignition = 1'b1; cyc();
        go_armed("same2");
        door = 4'b0001; cyc();
        door = 4'b0000;
        check("same.new_val", timer, 2);

        // Randomized traffic against the model.
        reset = 1'b1; ignition = 1'b0; door = '0; cyc();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 499) == 0);
            one_hz_enable = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) ignition = ~ignition;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 11) == 0) door[b] = ~door[b];
            reprogram = ($urandom_range(0, 19) == 0);
            prog_sel = 2'($urandom_range(0, 3));
            prog_val = 4'($urandom_range(0, 15));
            cyc();
            check("rand.state", state, m_mode);
            check("rand.timer", timer, m_left);
            check("rand.trig_door", trig_door, m_trig);
            check("rand.siren", siren, int'(m_mode == 2));
            check("rand.status", status,
                  (m_mode == 0) ? int'(m_blink) : int'(m_mode == 1 || m_mode == 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
